bp_fe_ras_ckpt: RTL and testbench
=================================

// Module: bp_fe_ras_ckpt
// PURPOSE
//  Parametrised return-address stack (RAS) for the FE PC generator, with checkpoint/restore.
//  - Pushes the return address on a call and pops it on a return.
//  - The stack is a circular buffer, so overflow overwrites the oldest entry instead of stalling.
//  - A call+return in the same cycle replaces the top entry.
//  - Exports a per-prediction checkpoint (TOS pointer, count, top value).
//  - Restoring a checkpoint repairs the stack after a mispredict or redirect from the backend.
// PARAMETERS
//  ras_idx_width_p  4   log2 of depth; els_lp = 2**ras_idx_width_p entries (power of 2 by construction)
//  eaddr_width_p    39  width of a stored return address
//  ckpt_width_lp    derived: ras_idx_width_p + (ras_idx_width_p+1) + eaddr_width_p
// PORTS
//  clk_i            in   1              clock; all state updates on posedge
//  reset_n_i        in   1              asynchronous, active-low reset
//  push_i           in   1              call: push push_addr_i
//  push_addr_i      in   eaddr_width_p  return address to push
//  pop_i            in   1              return: pop the top entry
//  restore_i        in   1              restore state from restore_ckpt_i; overrides push_i/pop_i
//  restore_ckpt_i   in   ckpt_width_lp  checkpoint previously taken from ckpt_o
//  data_o           out  eaddr_width_p  top-of-stack address; 0 when v_o=0
//  v_o              out  1              stack non-empty (count != 0)
//  ckpt_o           out  ckpt_width_lp  {tos, count, mem[tos]} of current (pre-update) state
//  overflow_o       out  1              this cycle's push overwrites the oldest entry
// BEHAVIOUR
//  State:
//  - tos_r: ras_idx_width_p bits, points at the top entry.
//  - count_r: ras_idx_width_p+1 bits, range 0..els_lp.
//  - mem: els_lp x eaddr_width_p.
//  Reset (reset_n_i=0, async):
//  - tos_r=0, count_r=0, so data_o=0, v_o=0, overflow_o=0, ckpt_o={0,0,mem[0]}.
//  - mem is NOT reset; outputs are gated by v_o.
//  - Deassertion is sampled synchronously; the first update is on the first posedge with reset_n_i=1.
//  All outputs are combinational from registered state. Update is visible the cycle after the event (1-cycle latency).
//  Priority per cycle, highest first:
//  - restore_i: tos_r<=ckpt.tos; count_r<=ckpt.count; mem[ckpt.tos]<=ckpt.top. push_i/pop_i ignored.
//  - push_i & pop_i & count_r!=0: mem[tos_r]<=push_addr_i (replace top); tos_r and count_r unchanged.
//  - push_i & pop_i & count_r==0: treated as push only.
//  - push_i: tos_r<=tos_r+1 (mod els_lp); mem[tos_r+1]<=push_addr_i; count_r<=min(count_r+1, els_lp).
//  - pop_i & count_r!=0: tos_r<=tos_r-1 (mod els_lp); count_r<=count_r-1. Entry is not cleared.
//  - pop_i & count_r==0: no state change (underflow ignored, no flag).
//  Full/overflow:
//  - overflow_o = push_i & ~pop_i & ~restore_i & (count_r==els_lp).
//  - On overflow the wrapped pointer lands on the oldest entry, which is overwritten; count stays els_lp.
//  Wrap-around: tos arithmetic is natural ras_idx_width_p-bit overflow; count never wraps.
//  Restore of a checkpoint with count=0 is legal; it still writes mem[ckpt.tos].
//  Reset asserted mid-operation: state clears immediately, independent of the clock.
// STRUCTURE
//  bp_fe_pkg:
//  - macro `declare_bp_fe_ras_ckpt_s(idx_width, eaddr_width): packed struct {tos, count, top}.
//  - macro `bp_fe_ras_ckpt_width(idx_width, eaddr_width).
//  - The PC generator stores checkpoints through this struct.
//  Sub-module bp_fe_ras_mem (els x width, 1 sync write port, 1 async read port at tos_r) holds the array.
//  The top level holds pointer/count logic and write-port muxing: one write per cycle, from restore, replace or push.
// TESTING (idx=2 -> 4 entries, eaddr 39)
//  1. Reset, push A,B,C -> data_o=C, v_o=1; pop x3 -> data_o B,A, then v_o=0, data_o=0.
//  2. Pop on empty, repeated 3x -> count stays 0, tos unchanged; next push D -> data_o=D, count=1.
//  3. Push 1..5 -> overflow_o=1 only on push 5; pops return 5,4,3,2, then v_o=0 (entry 1 lost).
//  4. Stack {A,B}: push X & pop together -> data_o=X, count=2; pop -> data_o=A.
//     On an empty stack, push+pop of Y -> data_o=Y, count=1.
//  5. Stack {A,B}: capture ckpt_o, push C, pop, pop, push Z; restore_i with the checkpoint plus push_i=1
//     -> data_o=B, count=2, push ignored; pop -> data_o=A.
//  6. Assert reset_n_i low between clock edges with count=3 -> v_o=0 before the next posedge.
//     Push after release -> count=1.

Source files
------------

// File: rtl/bp_fe_ras_ckpt_pkg.sv
// Shared types for the FE return-address stack: checkpoint struct macros,
// width helper and the per-cycle operation decode.
`ifndef BP_FE_RAS_CKPT_PKG_SV
`define BP_FE_RAS_CKPT_PKG_SV

`define DECLARE_BP_FE_RAS_CKPT_S(idx_width, eaddr_width) \
    typedef struct packed { \
        logic [(idx_width)-1:0]   tos; \
        logic [(idx_width):0]     count; \
        logic [(eaddr_width)-1:0] top; \
    } bp_fe_ras_ckpt_s

`define BP_FE_RAS_CKPT_WIDTH(idx_width, eaddr_width) \
    ((idx_width) + (idx_width) + 1 + (eaddr_width))

package bp_fe_ras_ckpt_pkg;

    typedef enum logic [2:0] {
        RAS_IDLE,
        RAS_RESTORE,
        RAS_REPLACE,
        RAS_PUSH,
        RAS_POP
    } ras_op_e;

    function automatic int unsigned ras_ckpt_width(input int unsigned idx_w,
                                                   input int unsigned eaddr_w);
        return idx_w + idx_w + 1 + eaddr_w;
    endfunction

endpackage

`endif

// File: rtl/bp_fe_ras_ckpt_if.sv
// Request/response bundle between the PC generator (master) and the RAS (slave).
interface bp_fe_ras_ckpt_if
    import bp_fe_ras_ckpt_pkg::*;
#(
    parameter int unsigned ras_idx_width_p = 4,
    parameter int unsigned eaddr_width_p   = 39
);
    localparam int unsigned ckpt_width_lp = ras_ckpt_width(ras_idx_width_p, eaddr_width_p);

    logic                     push;
    logic [eaddr_width_p-1:0] push_addr;
    logic                     pop;
    logic                     restore;
    logic [ckpt_width_lp-1:0] restore_ckpt;
    logic [eaddr_width_p-1:0] data;
    logic                     v;
    logic [ckpt_width_lp-1:0] ckpt;
    logic                     overflow;

    modport master (
        output push, push_addr, pop, restore, restore_ckpt,
        input  data, v, ckpt, overflow
    );

    modport slave (
        input  push, push_addr, pop, restore, restore_ckpt,
        output data, v, ckpt, overflow
    );
endinterface

// File: rtl/bp_fe_ras_mem.sv
// RAS storage: one synchronous write port, one asynchronous read port; not reset.
module bp_fe_ras_mem #(
    parameter int unsigned els_p       = 16,
    parameter int unsigned idx_width_p = 4,
    parameter int unsigned width_p     = 39
) (
    input  logic                   clk_i,
    input  logic                   w_v_i,
    input  logic [idx_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]     w_data_i,
    input  logic [idx_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]     r_data_o
);
    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];
endmodule

// File: rtl/bp_fe_ras_ckpt.sv
// Circular return-address stack with checkpoint export/restore for the FE PC generator.
module bp_fe_ras_ckpt
    import bp_fe_ras_ckpt_pkg::*;
#(
    parameter int unsigned ras_idx_width_p = 4,
    parameter int unsigned eaddr_width_p   = 39
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_fe_ras_ckpt_if.slave       ras_if
);
    localparam int unsigned els_lp  = 1 << ras_idx_width_p;
    localparam int unsigned cnt_w_lp = ras_idx_width_p + 1;

    `DECLARE_BP_FE_RAS_CKPT_S(ras_idx_width_p, eaddr_width_p);

    logic [ras_idx_width_p-1:0] tos_q, tos_d;
    logic [cnt_w_lp-1:0]        count_q, count_d;
    logic                       w_v;
    logic [ras_idx_width_p-1:0] w_addr;
    logic [eaddr_width_p-1:0]   w_data;
    logic [eaddr_width_p-1:0]   top_data;
    logic                       empty, full;
    bp_fe_ras_ckpt_s            rck;
    ras_op_e                    op;

    assign rck   = ras_if.restore_ckpt;
    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_w_lp'(els_lp));

    // Push+pop on an empty stack has no top to replace, so it degrades to a push.
    always_comb begin
        op = RAS_IDLE;
        if (ras_if.restore)                                 op = RAS_RESTORE;
        else if (ras_if.push && ras_if.pop && !empty)       op = RAS_REPLACE;
        else if (ras_if.push)                               op = RAS_PUSH;
        else if (ras_if.pop && !empty)                      op = RAS_POP;
    end

    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        w_v     = 1'b0;
        w_addr  = tos_q;
        w_data  = ras_if.push_addr;
        unique case (op)
            RAS_RESTORE: begin
                tos_d   = rck.tos;
                count_d = rck.count;
                w_v     = 1'b1;
                w_addr  = rck.tos;
                w_data  = rck.top;
            end
            RAS_REPLACE: w_v = 1'b1;
            RAS_PUSH: begin
                tos_d   = tos_q + 1'b1;
                count_d = full ? count_q : count_q + 1'b1;
                w_v     = 1'b1;
                w_addr  = tos_q + 1'b1;
            end
            RAS_POP: begin
                tos_d   = tos_q - 1'b1;
                count_d = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tos_q   <= '0;
            count_q <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
        end
    end

    bp_fe_ras_mem #(
        .els_p       (els_lp),
        .idx_width_p (ras_idx_width_p),
        .width_p     (eaddr_width_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (w_v),
        .w_addr_i (w_addr),
        .w_data_i (w_data),
        .r_addr_i (tos_q),
        .r_data_o (top_data)
    );

    assign ras_if.v        = !empty;
    assign ras_if.data     = empty ? '0 : top_data;
    assign ras_if.ckpt     = {tos_q, count_q, top_data};
    assign ras_if.overflow = ras_if.push & ~ras_if.pop & ~ras_if.restore & full;
endmodule

// File: tb/tb_bp_fe_ras_ckpt.sv
// Directed bench for the 4-entry RAS: push/pop, underflow, overflow, replace, restore, async reset.
module tb_bp_fe_ras_ckpt;
    localparam int unsigned IDX = 2;
    localparam int unsigned EW  = 39;
    localparam int unsigned CKW = IDX + IDX + 1 + EW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    logic [CKW-1:0] saved_ckpt;

    bp_fe_ras_ckpt_if #(.ras_idx_width_p(IDX), .eaddr_width_p(EW)) ras ();

    bp_fe_ras_ckpt #(.ras_idx_width_p(IDX), .eaddr_width_p(EW)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .ras_if    (ras)
    );

    always #5 clk = ~clk;

    localparam logic [EW-1:0] A = 39'h00_1000_0000;
    localparam logic [EW-1:0] B = 39'h00_2000_0004;
    localparam logic [EW-1:0] C = 39'h00_3000_0008;
    localparam logic [EW-1:0] D = 39'h7F_DEAD_BEEF;
    localparam logic [EW-1:0] X = 39'h11_1111_1110;
    localparam logic [EW-1:0] Y = 39'h22_2222_2220;
    localparam logic [EW-1:0] Z = 39'h33_3333_3330;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] cnt();
        return 64'(ras.ckpt[EW +: IDX+1]);
    endfunction

    function automatic logic [63:0] tos();
        return 64'(ras.ckpt[EW+IDX+1 +: IDX]);
    endfunction

    // Apply one cycle of stimulus (inputs set just after a posedge), then idle.
    task automatic step(input logic p, input logic o, input logic [EW-1:0] a);
        ras.push = p; ras.pop = o; ras.push_addr = a;
        @(posedge clk); #1;
        ras.push = 1'b0; ras.pop = 1'b0; ras.restore = 1'b0; ras.push_addr = '0;
    endtask

    initial begin
        ras.push = 1'b0; ras.pop = 1'b0; ras.restore = 1'b0;
        ras.push_addr = '0; ras.restore_ckpt = '0;

        // 1. reset, push A,B,C, pop x3
        #12;
        chk("rst_v", 64'(ras.v), 64'd0);
        chk("rst_data", 64'(ras.data), 64'd0);
        chk("rst_ovf", 64'(ras.overflow), 64'd0);
        chk("rst_cnt", cnt(), 64'd0);
        chk("rst_tos", tos(), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1, 0, A); step(1, 0, B); step(1, 0, C);
        chk("t1_data_C", 64'(ras.data), 64'(C));
        chk("t1_v", 64'(ras.v), 64'd1);
        chk("t1_cnt3", cnt(), 64'd3);
        step(0, 1, '0); chk("t1_pop_B", 64'(ras.data), 64'(B));
        step(0, 1, '0); chk("t1_pop_A", 64'(ras.data), 64'(A));
        step(0, 1, '0);
        chk("t1_empty_v", 64'(ras.v), 64'd0);
        chk("t1_empty_data", 64'(ras.data), 64'd0);

        // 2. underflow ignored
        for (int i = 0; i < 3; i++) begin
            step(0, 1, '0);
            chk("t2_uf_cnt", cnt(), 64'd0);
            chk("t2_uf_tos", tos(), 64'd0);
        end
        step(1, 0, D);
        chk("t2_push_D", 64'(ras.data), 64'(D));
        chk("t2_cnt1", cnt(), 64'd1);
        step(0, 1, '0);

        // 3. overflow on 5th push into 4 entries
        for (int i = 1; i <= 5; i++) begin
            ras.push = 1'b1; ras.push_addr = EW'(i); #1;
            chk("t3_ovf", 64'(ras.overflow), (i == 5) ? 64'd1 : 64'd0);
            step(1, 0, EW'(i));
        end
        chk("t3_cnt_full", cnt(), 64'd4);
        chk("t3_top5", 64'(ras.data), 64'd5);
        for (int i = 4; i >= 2; i--) begin
            step(0, 1, '0);
            chk("t3_pop", 64'(ras.data), 64'(i));
        end
        step(0, 1, '0);
        chk("t3_lost1_v", 64'(ras.v), 64'd0);

        // 4. replace top; push+pop on empty acts as push
        step(1, 0, A); step(1, 0, B);
        ras.push = 1'b1; ras.pop = 1'b1; #1;
        chk("t4_no_ovf_replace", 64'(ras.overflow), 64'd0);
        step(1, 1, X);
        chk("t4_repl_X", 64'(ras.data), 64'(X));
        chk("t4_repl_cnt", cnt(), 64'd2);
        step(0, 1, '0);
        chk("t4_pop_A", 64'(ras.data), 64'(A));
        step(0, 1, '0);
        step(1, 1, Y);
        chk("t4_empty_pp_Y", 64'(ras.data), 64'(Y));
        chk("t4_empty_pp_cnt", cnt(), 64'd1);
        step(0, 1, '0);

        // 5. checkpoint / restore
        step(1, 0, A); step(1, 0, B);
        saved_ckpt = ras.ckpt;
        chk("t5_ckpt_top", 64'(saved_ckpt[EW-1:0]), 64'(B));
        step(1, 0, C); step(0, 1, '0); step(0, 1, '0); step(1, 0, Z);
        chk("t5_pre_Z", 64'(ras.data), 64'(Z));
        ras.restore = 1'b1; ras.restore_ckpt = saved_ckpt; #1;
        chk("t5_no_ovf_restore", 64'(ras.overflow), 64'd0);
        step(1, 0, D);
        chk("t5_rest_B", 64'(ras.data), 64'(B));
        chk("t5_rest_cnt", cnt(), 64'd2);
        step(0, 1, '0);
        chk("t5_pop_A", 64'(ras.data), 64'(A));
        chk("t5_pop_cnt", cnt(), 64'd1);

        // 6. async reset between edges
        step(1, 0, C); step(1, 0, D);
        chk("t6_cnt3", cnt(), 64'd3);
        #2 rst_n = 1'b0; #1;
        chk("t6_async_v", 64'(ras.v), 64'd0);
        chk("t6_async_cnt", cnt(), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step(1, 0, A);
        chk("t6_post_cnt", cnt(), 64'd1);
        chk("t6_post_data", 64'(ras.data), 64'(A));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
